// File: rtl/fifo_reader.sv
// fifo_reader: pops a FIFO into a 2-entry buffer and serves a valid/ready stream.
// flush drops buffered words and drains the FIFO without counting them.
module fifo_reader #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic             busy,
  output logic [CNTW-1:0]  count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [CNTW-1:0]  cnt;

  logic             hs;
  logic [1:0]       occ_d;
  logic [1:0]       occ_n;
  logic [WIDTH-1:0] head_n;
  logic [WIDTH-1:0] tail_n;

  assign out_valid = (occ != 2'd0) && (state != FLUSH);
  assign out_data  = head;
  assign busy      = (state != IDLE);
  assign count     = cnt;
  assign hs        = out_valid & out_ready;

  always_comb begin
    fifo_pop = 1'b0;
    unique case (1'b1)
      !rst:           fifo_pop = 1'b0;
      state == FLUSH: fifo_pop = !fifo_empty;
      default:        fifo_pop = !fifo_empty && (occ < 2'd2) && !flush;
    endcase
  end

  // Dequeue first, then the popped word lands in the first free slot.
  always_comb begin
    occ_d  = occ - {1'b0, hs};
    head_n = hs ? tail : head;
    tail_n = tail;
    if (fifo_pop) begin
      if (occ_d == 2'd0) head_n = fifo_data;
      else               tail_n = fifo_data;
    end
    occ_n = occ_d + {1'b0, fifo_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      occ   <= 2'd0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
    end else begin
      if (hs) cnt <= cnt + 1'b1;
      if (state == FLUSH) begin
        if (fifo_empty) state <= IDLE;
      end else if (flush) begin
        occ   <= 2'd0;
        state <= FLUSH;
      end else begin
        occ   <= occ_n;
        head  <= head_n;
        tail  <= tail_n;
        state <= (occ_n != 2'd0) ? STREAM : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-backed FIFO model and an output scoreboard.
// CNTW is 4 so the counter wrap is reachable quickly.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_pop;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       flush = 1'b0;
  logic       busy;
  logic [3:0] count;

  fifo_reader #(.WIDTH(8), .CNTW(4)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_pop(fifo_pop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush),
    .busy(busy),
    .count(count)
  );

  always #5 clk = ~clk;

  logic [7:0] fq[$];
  logic [7:0] sb[$];
  int         nchk = 0;
  int         nfail = 0;
  int         npop = 0;
  logic [3:0] exp_cnt = 4'd0;

  task automatic upd();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    sb.push_back(w);
    upd();
  endtask

  task automatic cyc();
    logic       p;
    logic       h;
    logic       r;
    logic [7:0] d;
    logic [7:0] e;
    #1;
    p = fifo_pop;
    h = out_valid & out_ready;
    r = rst;
    d = out_data;
    if (h) begin
      nchk++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL sb_underflow: got %h, expected no word", d);
      end else begin
        e = sb.pop_front();
        if (d !== e) begin
          nfail++;
          $display("FAIL sb_data: got %h, expected %h", d, e);
        end
      end
      if (r) exp_cnt = exp_cnt + 4'd1;
    end
    if (!r) exp_cnt = 4'd0;
    if (p) npop++;
    @(posedge clk);
    #1;
    if (p && fq.size() > 0) void'(fq.pop_front());
    upd();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    for (int i = 0; i < 2; i++) begin
      #1;
      nchk++;
      if (fifo_pop !== 1'b0) begin
        nfail++;
        $display("FAIL rst_pop: got %b, expected 0", fifo_pop);
      end
      cyc();
    end
    rst = 1'b1;
    #1;
    nchk++;
    if ({out_valid, busy, count} !== 6'd0) begin
      nfail++;
      $display("FAIL rst_out: got v=%b b=%b c=%0d, expected 0", out_valid, busy, count);
    end
    fq.delete();
    sb.delete();
    upd();
  endtask

  task automatic test_stream();
    logic [7:0] ex[3];
    ex[0] = 8'h11;
    ex[1] = 8'h22;
    ex[2] = 8'h33;
    for (int i = 0; i < 3; i++) push(ex[i]);
    out_ready = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++;
      if (out_valid !== 1'b1 || out_data !== ex[i]) begin
        nfail++;
        $display("FAIL stream_%0d: got v=%b d=%h, expected 1 %h", i, out_valid, out_data, ex[i]);
      end
      cyc();
    end
    nchk++;
    if (count !== 4'd3 || busy !== 1'b0 || count !== exp_cnt) begin
      nfail++;
      $display("FAIL stream_end: got c=%0d b=%b, expected 3 0", count, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    npop = 0;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++;
      if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
        nfail++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h, expected 1 a0", i, out_valid, out_data);
      end
      cyc();
    end
    nchk++;
    if (npop != 2 || fq.size() != 3) begin
      nfail++;
      $display("FAIL bp_pops: got pops=%0d left=%0d, expected 2 3", npop, fq.size());
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      nchk++;
      if (out_valid !== 1'b1) begin
        nfail++;
        $display("FAIL bp_gap_%0d: got v=%b, expected 1", i, out_valid);
      end
      cyc();
    end
    nchk++;
    if (sb.size() != 0 || count !== 4'd8 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL bp_end: got left=%0d c=%0d b=%b, expected 0 8 0", sb.size(), count, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    int n;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    cyc();
    cyc();
    nchk++;
    if (fq.size() != 4 || out_valid !== 1'b1) begin
      nfail++;
      $display("FAIL fl_pre: got left=%0d v=%b, expected 4 1", fq.size(), out_valid);
    end
    flush = 1'b1;
    #1;
    nchk++;
    if (fifo_pop !== 1'b0) begin
      nfail++;
      $display("FAIL fl_pop: got %b, expected 0", fifo_pop);
    end
    cyc();
    flush = 1'b0;
    npop = 0;
    n = 0;
    while (busy && n < 10) begin
      #1;
      nchk++;
      if (out_valid !== 1'b0) begin
        nfail++;
        $display("FAIL fl_valid: got %b, expected 0", out_valid);
      end
      cyc();
      n++;
    end
    nchk++;
    if (n != 5 || npop != 4 || count !== 4'd8 || fq.size() != 0) begin
      nfail++;
      $display("FAIL fl_end: got cyc=%0d pops=%0d c=%0d left=%0d, expected 5 4 8 0",
               n, npop, count, fq.size());
    end
    sb.delete();
  endtask

  task automatic test_flush_hs();
    out_ready = 1'b0;
    push(8'hD0);
    push(8'hD1);
    cyc();
    cyc();
    out_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    nchk++;
    if (count !== 4'd9 || out_valid !== 1'b0 || busy !== 1'b1 || sb.size() != 1) begin
      nfail++;
      $display("FAIL flhs_mid: got c=%0d v=%b b=%b left=%0d, expected 9 0 1 1",
               count, out_valid, busy, sb.size());
    end
    sb.delete();
    cyc();
    nchk++;
    if (busy !== 1'b0 || count !== exp_cnt) begin
      nfail++;
      $display("FAIL flhs_end: got b=%b c=%0d, expected 0 %0d", busy, count, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int n;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(i + 1));
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    nchk++;
    if (sb.size() != 0 || count !== 4'd1 || count !== exp_cnt) begin
      nfail++;
      $display("FAIL wrap: got left=%0d c=%0d, expected 0 1", sb.size(), count);
    end
    out_ready = 1'b0;
    cyc();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
    cyc();
    cyc();
    #1;
    nchk++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || count !== 4'd1) begin
      nfail++;
      $display("FAIL mr_pre: got b=%b v=%b c=%0d, expected 1 1 1", busy, out_valid, count);
    end
    rst = 1'b0;
    cyc();
    nchk++;
    if ({out_valid, busy, count, out_data, fifo_pop} !== 15'd0) begin
      nfail++;
      $display("FAIL mr_out: got v=%b b=%b c=%0d d=%h p=%b, expected 0",
               out_valid, busy, count, out_data, fifo_pop);
    end
    rst = 1'b1;
    fq.delete();
    sb.delete();
    upd();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_hs();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the `FIFO` block. It watches the FIFO's `empty` flag and combinational `data_out`, and generates `pop` itself. Each word it removes is moved into a 2-entry output buffer and presented downstream on a valid/ready stream. It sits between a `FIFO` instance and any stream consumer, so the consumer never has to drive `pop` or sample `data_out` directly. A flush command discards all buffered words and drains the FIFO.

## Interface
- `WIDTH`, 8, data word width; must match the attached FIFO.
- `CNTW`, 16, width of the delivered-word counter.

- `clk`  in  1  rising-edge clock, shared with the FIFO.
- `rst`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`, the current head word, combinational.
- `fifo_pop`  out  1  FIFO `pop`.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  WIDTH  head of the output buffer.
- `flush`  in  1  single-cycle flush request.
- `busy`  out  1  state ≠ IDLE.
- `count`  out  CNTW  words accepted downstream since reset; wraps modulo 2^CNTW.

## Operation
- Output buffer: 2 entries with a head register and a tail register, plus occupancy `occ` ∈ {0,1,2}.
  - `out_valid = (occ != 0) & (state != FLUSH)`.
  - `out_data` = head entry.
- Pop rule, in IDLE and STREAM:
  - `fifo_pop = !fifo_empty & (occ < 2) & !flush`.
  - This is a function of registered state, `fifo_empty` and `flush` only; there is no combinational path from `out_ready` to `fifo_pop`.
- Capture: in a cycle where `fifo_pop=1`, `fifo_data` is written at the next edge into the first free slot, after any same-cycle dequeue.
- Simultaneous enqueue and dequeue:
  - At `occ=1`: `occ` stays 1 and the head is replaced by the new word.
  - At `occ=2`: no pop is issued, because the pop rule requires `occ < 2`.
- Dequeue: a downstream handshake is `out_valid & out_ready`. On a handshake the tail shifts to the head, `occ` decrements, and `count` increments.
- State machine:
  - IDLE → STREAM when `occ` becomes nonzero.
  - STREAM → IDLE when `occ` becomes 0.
  - IDLE or STREAM → FLUSH on `flush=1`.
  - FLUSH → IDLE in the first FLUSH cycle that sees `fifo_empty=1`.
- Flush cycle (the cycle `flush=1` is sampled):
  - `fifo_pop=0`.
  - A handshake in that same cycle still completes and counts.
  - At the next edge `occ` becomes 0 and state becomes FLUSH.
- FLUSH:
  - `fifo_pop = !fifo_empty`; popped words are discarded and not counted.
  - `out_valid=0`.
  - `flush` is ignored.
- Reset (`rst=0` at an edge), regardless of state:
  - state=IDLE, `occ=0`, `count=0`, buffer data=0.
  - Outputs after that edge: `out_valid=0`, `out_data=0`, `busy=0`, `count=0`.
  - While `rst=0`, `fifo_pop` is forced to 0.
  - Resetting the FIFO itself, whose reset is active-high, is the integrator's job.

## Timing
- `fifo_pop` is combinational. The word popped is the `fifo_data` value present in that same cycle.
- Latency: a word at the FIFO head with `occ=0` in IDLE/STREAM appears on `out_valid`/`out_data` one cycle after its pop cycle.
- Throughput: with `out_ready` held at 1 and the FIFO never empty, one word per cycle after the first-word latency.
- Back-pressure:
  - With `out_ready=0`, the buffer fills to 2 and popping stops.
  - `out_data` and `out_valid` hold stable while `out_valid & !out_ready`.
- Flush length: 1 flush cycle plus N FLUSH cycles for N words left in the FIFO, plus one cycle to observe empty. `busy` falls on the edge after that observation.
- `count` wraps: at 2^CNTW−1, one handshake → 0.

## Test plan
- Reset:
  - Hold `rst=0` for 2 cycles with `fifo_empty=0` → `fifo_pop=0` throughout.
  - After release: `out_valid=0`, `count=0`, `busy=0`.
- Streaming:
  - Push 0x11,0x22,0x33 into an 8-deep FIFO, `out_ready=1` → `out_data` 0x11,0x22,0x33 on consecutive cycles.
  - `count=3`; `busy` falls the cycle after the last handshake.
- Back-pressure:
  - Push 5 words with `out_ready=0` → exactly 2 pops, `occ=2`, `out_data`=first word stable; FIFO keeps 3 words.
  - Raise `out_ready` → all 5 delivered in order with no gaps or duplicates.
- Flush:
  - With `occ=2`, 4 words in the FIFO and `out_ready=0`, pulse `flush` → `out_valid` low from the next cycle.
  - 4 discard pops follow; `count` is unchanged; then IDLE with `fifo_empty=1`.
- Flush with simultaneous handshake: pulse `flush` while `out_valid & out_ready` → that word is counted (`count`+1) and the remaining buffered word is dropped.
- Wrap and mid-operation reset:
  - `CNTW=4`: deliver 17 words → `count=1`.
  - Assert `rst=0` in STREAM with `occ=2` → next cycle `out_valid=0`, `count=0`, IDLE.
